dmem_route_bridge: RTL and testbench
====================================

// Module: dmem_route_bridge
// PURPOSE
// - Consumes the physical address and cacheable flag produced by the address-translation stage for the data
//   side. Steers each CPU sram-like data request to the D-cache port (kseg0, cached) or the uncached bus port
//   (kseg1/other, uncached).
// - Returns the matching response to the CPU; sits between the MEM stage and the cache/AXI bridge.
// - Single outstanding transaction; ordering is guaranteed by construction.
// PARAMETERS
// - ADDR_W   32  address width
// - DATA_W   32  data width
// - STRAY_W  8   width of saturating stray-response counter
// PORTS
// - clk          in   1       clock, all logic on posedge
// - resetn       in   1       synchronous reset, active-low
// - cpu_req      in   1       CPU request valid
// - cpu_wr       in   1       1=write, 0=read
// - cpu_size     in   2       0=byte, 1=half, 2=word
// - cpu_addr     in   ADDR_W  physical address (post-translation)
// - cpu_wdata    in   DATA_W  write data
// - cpu_cached   in   1       1=route to cache port, 0=uncache port
// - cpu_addr_ok  out  1       request accepted this cycle
// - cpu_data_ok  out  1       response valid this cycle
// - cpu_rdata    out  DATA_W  read data (valid with cpu_data_ok on reads)
// - c_req/u_req  out  1       downstream request, cache/uncache port
// - c_wr,u_wr / c_size,u_size / c_addr,u_addr / c_wdata,u_wdata  out  1/2/ADDR_W/DATA_W  forwarded fields
// - c_addr_ok,u_addr_ok  in  1  downstream accepted
// - c_data_ok,u_data_ok  in  1  downstream response
// - c_rdata,u_rdata      in  DATA_W  downstream read data
// - stray_cnt    out  STRAY_W  count of unexpected downstream data_ok pulses, saturating
// BEHAVIOUR
// - Reset (resetn=0 at posedge): state=IDLE, stray_cnt=0. All req/addr_ok/data_ok outputs read 0 during reset.
//   rdata is 0 during reset.
// - States: IDLE, WAIT_C, WAIT_U.
// - IDLE:
//   - c_req = cpu_req & cpu_cached; u_req = cpu_req & ~cpu_cached. Unselected port req=0.
//   - wr/size/addr/wdata are forwarded combinationally to both ports.
//   - cpu_addr_ok = selected port addr_ok, gated by cpu_req.
//   - Handshake (cpu_req & cpu_addr_ok): next state is WAIT_C or WAIT_U per cpu_cached.
// - WAIT_C / WAIT_U:
//   - c_req=u_req=0 and cpu_addr_ok=0; new requests stall.
//   - cpu_data_ok = selected port data_ok, same cycle (0 added latency). cpu_rdata = selected rdata.
//   - On data_ok, go to IDLE. A new request is accepted no earlier than the next cycle (1-cycle bubble).
// - Downstream addr_ok/data_ok in the same cycle as req (zero-latency slave): handshake in IDLE, then data_ok
//   is consumed in the following WAIT cycle only. Slaves must not assert data_ok in the addr_ok cycle.
// - Stray response: data_ok on the non-selected port, or any data_ok in IDLE. It is ignored (not forwarded)
//   and increments stray_cnt, saturating at all-ones.
//   - Both ports' data_ok in a WAIT cycle: the selected one completes and the other counts as stray (+1).
// - cpu_rdata when no response is valid: holds the last delivered value; 0 after reset.
// - Reset mid-transaction: state returns to IDLE and the outstanding request is dropped. A late downstream
//   data_ok after reset is counted as stray.
// - cpu_cached is sampled only at the handshake cycle; changes while waiting have no effect.
// CONFIGURATION
// - Macro DMEM_ROUTE_RSPREG_EN.
// - Defined:
//   - The response is registered: cpu_data_ok/cpu_rdata assert 1 cycle after the downstream data_ok.
//   - State stays WAIT_x until the registered response issues, so the bubble becomes 2 cycles.
//   - Registered data_ok resets to 0.
// - Undefined: combinational response path as above.
// TESTING
// - Cached read: cpu_req=1, cpu_cached=1, addr=0x0000_1000; c_addr_ok=1 at cycle 0; c_data_ok=1 at cycle 3,
//   c_rdata=0xDEADBEEF -> c_req=1 only at cycle 0, u_req=0 throughout; cpu_data_ok=1 with rdata=0xDEADBEEF
//   at cycle 3 (cycle 4 with macro).
// - Uncached write: cached=0, wr=1, size=2, addr=0x1FAF_F000, wdata=0x12345678; u_addr_ok delayed 2 cycles
//   -> u_req held 3 cycles with stable fields; cpu_addr_ok=1 only in cycle 2; then 1 cpu_data_ok pulse.
// - Back-to-back cached then uncached: the second request is held off (cpu_addr_ok=0) until the cycle after
//   the first cpu_data_ok; then routed to u_req.
// - Stray: in IDLE pulse u_data_ok 3 times -> stray_cnt=3, cpu_data_ok stays 0. Force 300 strays with
//   STRAY_W=8 -> stray_cnt=255.
// - Dual response in WAIT_C: c_data_ok=u_data_ok=1 same cycle -> cpu_rdata=c_rdata, stray_cnt+1.
// - Reset mid-op: resetn=0 for 1 cycle during WAIT_U -> IDLE, cpu_data_ok=0. Subsequent u_data_ok -> stray_cnt=1.

Source files
------------

// File: rtl/dmem_route_bridge.sv
// Data-side request router: steers sram-like CPU requests to the D-cache port (cached) or uncached bus port.
// Optional macro DMEM_ROUTE_RSPREG_EN registers the CPU response path, adding one cycle of response latency.
module dmem_route_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int STRAY_W = 8
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               cpu_req,
   input  logic               cpu_wr,
   input  logic [1:0]         cpu_size,
   input  logic [ADDR_W-1:0]  cpu_addr,
   input  logic [DATA_W-1:0]  cpu_wdata,
   input  logic               cpu_cached,
   output logic               cpu_addr_ok,
   output logic               cpu_data_ok,
   output logic [DATA_W-1:0]  cpu_rdata,
   output logic               c_req,
   output logic               c_wr,
   output logic [1:0]         c_size,
   output logic [ADDR_W-1:0]  c_addr,
   output logic [DATA_W-1:0]  c_wdata,
   input  logic               c_addr_ok,
   input  logic               c_data_ok,
   input  logic [DATA_W-1:0]  c_rdata,
   output logic               u_req,
   output logic               u_wr,
   output logic [1:0]         u_size,
   output logic [ADDR_W-1:0]  u_addr,
   output logic [DATA_W-1:0]  u_wdata,
   input  logic               u_addr_ok,
   input  logic               u_data_ok,
   input  logic [DATA_W-1:0]  u_rdata,
   output logic [STRAY_W-1:0] stray_cnt
);

   typedef enum logic [1:0] {IDLE, WAIT_C, WAIT_U} state_t;

   state_t             state_q;
   state_t             state_d;
   logic [DATA_W-1:0]  rdata_q;
   logic [STRAY_W-1:0] stray_q;
   logic               dn_ok;
   logic [DATA_W-1:0]  dn_rdata;
   logic               c_stray;
   logic               u_stray;
   logic [STRAY_W:0]   stray_sum;
`ifdef DMEM_ROUTE_RSPREG_EN
   logic               rsp_vld_q;
`endif

   assign c_wr    = cpu_wr;
   assign c_size  = cpu_size;
   assign c_addr  = cpu_addr;
   assign c_wdata = cpu_wdata;
   assign u_wr    = cpu_wr;
   assign u_size  = cpu_size;
   assign u_addr  = cpu_addr;
   assign u_wdata = cpu_wdata;

   // Any data_ok that does not complete the outstanding request is a stray and only feeds the counter.
   always_comb begin
      state_d     = state_q;
      c_req       = 1'b0;
      u_req       = 1'b0;
      cpu_addr_ok = 1'b0;
      dn_ok       = 1'b0;
      dn_rdata    = c_rdata;
      c_stray     = 1'b0;
      u_stray     = 1'b0;
      case (state_q)
         IDLE: begin
            c_req       = cpu_req & cpu_cached;
            u_req       = cpu_req & ~cpu_cached;
            cpu_addr_ok = (c_req & c_addr_ok) | (u_req & u_addr_ok);
            if (cpu_addr_ok) begin
               state_d = cpu_cached ? WAIT_C : WAIT_U;
            end
            c_stray = c_data_ok;
            u_stray = u_data_ok;
         end
         WAIT_C: begin
            dn_rdata = c_rdata;
            u_stray  = u_data_ok;
`ifdef DMEM_ROUTE_RSPREG_EN
            dn_ok   = c_data_ok & ~rsp_vld_q;
            c_stray = c_data_ok & rsp_vld_q;
            if (rsp_vld_q) begin
               state_d = IDLE;
            end
`else
            dn_ok = c_data_ok;
            if (c_data_ok) begin
               state_d = IDLE;
            end
`endif
         end
         WAIT_U: begin
            dn_rdata = u_rdata;
            c_stray  = c_data_ok;
`ifdef DMEM_ROUTE_RSPREG_EN
            dn_ok   = u_data_ok & ~rsp_vld_q;
            u_stray = u_data_ok & rsp_vld_q;
            if (rsp_vld_q) begin
               state_d = IDLE;
            end
`else
            dn_ok = u_data_ok;
            if (u_data_ok) begin
               state_d = IDLE;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
      if (!resetn) begin
         c_req       = 1'b0;
         u_req       = 1'b0;
         cpu_addr_ok = 1'b0;
         dn_ok       = 1'b0;
         c_stray     = 1'b0;
         u_stray     = 1'b0;
      end
   end

   // Two strays can land in one cycle, so the sum carries one extra bit to detect saturation.
   assign stray_sum = {1'b0, stray_q} + (STRAY_W+1)'(c_stray) + (STRAY_W+1)'(u_stray);
   assign stray_cnt = stray_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         stray_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (dn_ok) begin
            rdata_q <= dn_rdata;
         end
         stray_q <= stray_sum[STRAY_W] ? '1 : stray_sum[STRAY_W-1:0];
      end
   end

`ifdef DMEM_ROUTE_RSPREG_EN
   // The captured response is presented from rdata_q one cycle after the downstream data_ok.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rsp_vld_q <= 1'b0;
      end else begin
         rsp_vld_q <= dn_ok;
      end
   end

   assign cpu_data_ok = resetn & rsp_vld_q;
   assign cpu_rdata   = resetn ? rdata_q : '0;
`else
   assign cpu_data_ok = dn_ok;
   assign cpu_rdata   = !resetn ? '0 : (dn_ok ? dn_rdata : rdata_q);
`endif

endmodule

// File: tb/tb_dmem_route_bridge.sv
// Randomized scoreboard bench for dmem_route_bridge: a cycle-level slave/CPU model predicts routing,
// response timing, held read data and the saturating stray counter.
`timescale 1ns/1ps
module tb_dmem_route_bridge;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int STRAY_W = 8;
   localparam int SMAX    = (1 << STRAY_W) - 1;
`ifdef DMEM_ROUTE_RSPREG_EN
   localparam int RSP = 1;
`else
   localparam int RSP = 0;
`endif

   logic               clk = 1'b0;
   logic               resetn;
   logic               cpu_req, cpu_wr, cpu_cached;
   logic [1:0]         cpu_size;
   logic [ADDR_W-1:0]  cpu_addr;
   logic [DATA_W-1:0]  cpu_wdata;
   logic               cpu_addr_ok, cpu_data_ok;
   logic [DATA_W-1:0]  cpu_rdata;
   logic               c_req, c_wr, u_req, u_wr;
   logic [1:0]         c_size, u_size;
   logic [ADDR_W-1:0]  c_addr, u_addr;
   logic [DATA_W-1:0]  c_wdata, u_wdata;
   logic               c_addr_ok, c_data_ok, u_addr_ok, u_data_ok;
   logic [DATA_W-1:0]  c_rdata, u_rdata;
   logic [STRAY_W-1:0] stray_cnt;

   always #5 clk = ~clk;

   dmem_route_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRAY_W(STRAY_W)) dut (
      .clk(clk), .resetn(resetn),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_cached(cpu_cached),
      .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
      .c_req(c_req), .c_wr(c_wr), .c_size(c_size), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_addr_ok(c_addr_ok), .c_data_ok(c_data_ok), .c_rdata(c_rdata),
      .u_req(u_req), .u_wr(u_wr), .u_size(u_size), .u_addr(u_addr), .u_wdata(u_wdata),
      .u_addr_ok(u_addr_ok), .u_data_ok(u_data_ok), .u_rdata(u_rdata),
      .stray_cnt(stray_cnt)
   );

   typedef struct {
      logic [DATA_W-1:0] data;
      int                due;
   } rsp_t;

   rsp_t              exp_q[$];
   int                tests = 0;
   int                fails = 0;
   int                cyc = 0;
   bit                run = 0;
   logic              exp_c_req, exp_u_req, exp_addr_ok;
   int                exp_stray;
   logic [DATA_W-1:0] last_rd;
   bit                have_txn, pending, pend_c, late_valid, late_c, gen_en, force_stray, flip;
   int                cnt, ready_at, stray_total, completions;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // One bus cycle: CPU master, both slaves and stray injection, plus the expectations they imply.
   task automatic applyStimulus(input bit do_reset);
      bit ready, accept, want, p;
      @(posedge clk);
      #1;
      cyc++;
      exp_stray = (stray_total > SMAX) ? SMAX : stray_total;
      c_data_ok = 1'b0;
      u_data_ok = 1'b0;
      c_rdata   = $urandom;
      u_rdata   = $urandom;
      c_addr_ok = 1'($urandom_range(0, 1));
      u_addr_ok = 1'($urandom_range(0, 1));
      if (do_reset) begin
         resetn      = 1'b0;
         cpu_req     = 1'b0;
         exp_c_req   = 1'b0;
         exp_u_req   = 1'b0;
         exp_addr_ok = 1'b0;
         if (pending) begin
            late_valid = 1'b1;
            late_c     = pend_c;
         end
         pending     = 1'b0;
         stray_total = 0;
         ready_at    = cyc + 1;
         return;
      end
      resetn = 1'b1;
      if (!have_txn && gen_en && $urandom_range(0, 2) != 0) begin
         have_txn   = 1'b1;
         cpu_wr     = 1'($urandom_range(0, 1));
         cpu_size   = 2'($urandom_range(0, 2));
         cpu_addr   = $urandom;
         cpu_wdata  = $urandom;
         cpu_cached = 1'($urandom_range(0, 1));
      end
      cpu_req     = have_txn;
      ready       = !pending && (cyc >= ready_at);
      exp_c_req   = have_txn && ready && cpu_cached;
      exp_u_req   = have_txn && ready && !cpu_cached;
      accept      = have_txn && ready && (cpu_cached ? c_addr_ok : u_addr_ok);
      exp_addr_ok = accept;
      if (pending) begin
         cnt--;
         if (cnt == 0) begin
            if (pend_c) begin
               c_data_ok = 1'b1;
               exp_q.push_back('{c_rdata, cyc + RSP});
            end else begin
               u_data_ok = 1'b1;
               exp_q.push_back('{u_rdata, cyc + RSP});
            end
            pending  = 1'b0;
            ready_at = cyc + 1 + RSP;
            completions++;
         end
      end
      if (!ready) begin
         if ($urandom_range(0, 7) == 0) begin
            if (pend_c) u_data_ok = 1'b1;
            else        c_data_ok = 1'b1;
            stray_total++;
         end
      end else begin
         want = 1'b0;
         p    = 1'b0;
         if (late_valid) begin
            want       = 1'b1;
            p          = late_c;
            late_valid = 1'b0;
         end else if (force_stray) begin
            want = 1'b1;
            p    = flip;
            flip = !flip;
         end else if ($urandom_range(0, 7) == 0) begin
            want = 1'b1;
            p    = 1'($urandom_range(0, 1));
         end
         if (want && !(accept && p == cpu_cached)) begin
            if (p) c_data_ok = 1'b1;
            else   u_data_ok = 1'b1;
            stray_total++;
         end
      end
      if (accept) begin
         pending  = 1'b1;
         pend_c   = cpu_cached;
         cnt      = $urandom_range(1, 3);
         have_txn = 1'b0;
      end
   endtask

   // Monitor: compares everything the DUT presents against the expectations and the response queue.
   task automatic checkOutput();
      rsp_t r;
      bit   exp_dok;
      if (!resetn) begin
         check("reset_c_req", 64'(c_req), 64'(0));
         check("reset_u_req", 64'(u_req), 64'(0));
         check("reset_addr_ok", 64'(cpu_addr_ok), 64'(0));
         check("reset_data_ok", 64'(cpu_data_ok), 64'(0));
         check("reset_rdata", 64'(cpu_rdata), 64'(0));
         last_rd = '0;
         return;
      end
      check("c_req", 64'(c_req), 64'(exp_c_req));
      check("u_req", 64'(u_req), 64'(exp_u_req));
      check("cpu_addr_ok", 64'(cpu_addr_ok), 64'(exp_addr_ok));
      if (exp_c_req) begin
         check("c_fields", {c_wdata, c_addr}, {cpu_wdata, cpu_addr});
         check("c_wr_size", 64'({c_wr, c_size}), 64'({cpu_wr, cpu_size}));
      end
      if (exp_u_req) begin
         check("u_fields", {u_wdata, u_addr}, {cpu_wdata, cpu_addr});
         check("u_wr_size", 64'({u_wr, u_size}), 64'({cpu_wr, cpu_size}));
      end
      check("stray_cnt", 64'(stray_cnt), 64'(exp_stray));
      exp_dok = (exp_q.size() != 0) && (exp_q[0].due == cyc);
      check("cpu_data_ok", 64'(cpu_data_ok), 64'(exp_dok));
      if (exp_dok) begin
         r = exp_q.pop_front();
         check("cpu_rdata", 64'(cpu_rdata), 64'(r.data));
         last_rd = r.data;
      end else begin
         check("rdata_hold", 64'(cpu_rdata), 64'(last_rd));
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (run) checkOutput();
      end
   end

   initial begin
      resetn      = 1'b0;
      cpu_req     = 1'b0;
      cpu_wr      = 1'b0;
      cpu_size    = 2'd0;
      cpu_addr    = '0;
      cpu_wdata   = '0;
      cpu_cached  = 1'b0;
      c_addr_ok   = 1'b0;
      u_addr_ok   = 1'b0;
      c_data_ok   = 1'b0;
      u_data_ok   = 1'b0;
      c_rdata     = '0;
      u_rdata     = '0;
      exp_c_req   = 1'b0;
      exp_u_req   = 1'b0;
      exp_addr_ok = 1'b0;
      exp_stray   = 0;
      last_rd     = '0;
      have_txn    = 1'b0;
      pending     = 1'b0;
      pend_c      = 1'b0;
      late_valid  = 1'b0;
      late_c      = 1'b0;
      gen_en      = 1'b0;
      force_stray = 1'b0;
      flip        = 1'b0;
      cnt         = 0;
      ready_at    = 0;
      stray_total = 0;
      completions = 0;
      run         = 1'b1;
      repeat (3) applyStimulus(1'b1);

      // A few strays in idle, then enough to saturate the counter.
      force_stray = 1'b1;
      repeat (3) applyStimulus(1'b0);
      force_stray = 1'b0;
      repeat (2) applyStimulus(1'b0);
      force_stray = 1'b1;
      repeat (300) applyStimulus(1'b0);
      force_stray = 1'b0;
      repeat (2) applyStimulus(1'b0);
      applyStimulus(1'b1);

      // Random traffic with occasional reset while a request is outstanding.
      gen_en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(pending && cnt >= 2 && $urandom_range(0, 30) == 0);
      end
      gen_en = 1'b0;
      repeat (8) applyStimulus(1'b0);
      @(negedge clk);
      #1;
      check("queue_drained", 64'(exp_q.size()), 64'(0));
      check("completions_seen", 64'(completions > 100), 64'(1));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
